// File: rtl/apb_audio_ctrl.sv
// APB control/data-entry stage of the audioport: command/status/config registers,
// a stereo sample FIFO, and tick-driven playback with a FIFO-low interrupt.
module apb_audio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h8c000000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        tick_in,
  output logic [31:0] audio_out,
  output logic        audio_valid_out,
  output logic [31:0] cfg_out,
  output logic        play_out,
  output logic        irq_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int HALF = FIFO_DEPTH / 2;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_reg, wptr_next, rptr_reg, rptr_next;
  logic [LW-1:0]   level_reg, level_next;
  logic [31:0]     cfg_reg, cfg_next;
  logic            under_reg, under_next;
  logic            irq_reg, irq_next;
  logic [31:0]     audio_reg, audio_next;
  logic            valid_reg;

  logic        access, addr_ok, sel_cmd, sel_stat, sel_cfg, sel_data;
  logic        full, empty, wr_ok, cmd_wr, clr, stop, start, ack;
  logic        push, pop_req, pop, irq_set;
  logic [31:0] offset, status;
  logic [LW-1:0] level_after_clr;

  assign access   = PSEL & PENABLE;
  assign offset   = PADDR - BASE_ADDR;
  assign addr_ok  = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
  assign sel_cmd  = addr_ok && (offset[3:2] == 2'd0);
  assign sel_stat = addr_ok && (offset[3:2] == 2'd1);
  assign sel_cfg  = addr_ok && (offset[3:2] == 2'd2);
  assign sel_data = addr_ok && (offset[3:2] == 2'd3);

  assign full  = (level_reg == LW'(FIFO_DEPTH));
  assign empty = (level_reg == '0);

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~addr_ok | (PWRITE & sel_stat) | (PWRITE & sel_data & full));
  assign wr_ok   = access & PWRITE & ~PSLVERR;

  assign cmd_wr = wr_ok & sel_cmd;
  assign start  = cmd_wr & PWDATA[0];
  assign stop   = cmd_wr & PWDATA[1];
  assign clr    = cmd_wr & PWDATA[2];
  assign ack    = cmd_wr & PWDATA[3];
  assign push   = wr_ok & sel_data;

  assign pop_req = tick_in & (state_reg == PLAY);
  assign pop     = pop_req & ~empty;

  assign status = {16'd0, 8'(level_reg), 3'd0, under_reg, irq_reg, full, empty,
                   state_reg == PLAY};

  always_comb begin
    PRDATA = 32'd0;
    if (access && !PWRITE && addr_ok) begin
      if (sel_stat) PRDATA = status;
      else if (sel_cfg) PRDATA = cfg_reg;
    end
  end

  // STOP is applied before START, so a combined STOP|START leaves the player running.
  always_comb begin
    state_next = state_reg;
    if (stop)  state_next = IDLE;
    if (start) state_next = PLAY;
  end

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    level_next = level_reg + LW'(push) - LW'(pop);
    under_next = under_reg;
    if (push) wptr_next = wptr_reg + AW'(1);
    if (pop)  rptr_next = rptr_reg + AW'(1);
    if (pop_req && empty) under_next = 1'b1;
    if (clr) begin
      wptr_next  = '0;
      rptr_next  = '0;
      level_next = '0;
      under_next = 1'b0;
    end
  end

  // START sees the FIFO level after any CLR carried in the same command word.
  assign level_after_clr = clr ? '0 : level_reg;
  assign irq_set = (start && (level_after_clr <= LW'(HALF))) ||
                   ((state_reg == PLAY) && pop && !push && !clr &&
                    (level_reg == LW'(HALF + 1)));

  always_comb begin
    irq_next = irq_reg;
    if (ack)     irq_next = 1'b0;
    if (irq_set) irq_next = 1'b1;
  end

  always_comb begin
    cfg_next   = cfg_reg;
    audio_next = audio_reg;
    if (wr_ok && sel_cfg) cfg_next = PWDATA;
    if (pop_req) audio_next = empty ? 32'd0 : mem[rptr_reg];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg] <= PWDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
      cfg_reg   <= 32'd0;
      under_reg <= 1'b0;
      irq_reg   <= 1'b0;
      audio_reg <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      level_reg <= level_next;
      cfg_reg   <= cfg_next;
      under_reg <= under_next;
      irq_reg   <= irq_next;
      audio_reg <= audio_next;
      valid_reg <= pop_req;
    end
  end

  assign audio_out       = audio_reg;
  assign audio_valid_out = valid_reg;
  assign cfg_out         = cfg_reg;
  assign play_out        = (state_reg == PLAY);
  assign irq_out         = irq_reg;

endmodule
